alu_cmd_issue: RTL and testbench

//  Upstream issue stage for the 4-bit combinational ALU. Buffers {A,B,sel} commands in a small FIFO
//  and drives one command at a time onto the ALU input ports. Captures the ALU result one cycle later
//  and presents it downstream on a valid/ready handshake. In-order, one command in flight at a time.

---
 rtl/alu_cmd_issue_if.sv | 71 +++++++
 rtl/alu_cmd_issue.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_issue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issue_if.sv
// Handshake/bus bundle between the command source, alu_cmd_issue, the ALU and the result sink.
// slave: issue-stage view (cmd in, alu_* out, alu_result in, res out); master: environment view.
interface alu_cmd_issue_if #(
  parameter int WIDTH = 4,
  parameter int SELW  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [SELW-1:0]  cmd_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SELW-1:0]  alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  logic             busy;

`ifdef ALU_FLAGS_EN
  logic             res_zero;
  logic             res_neg;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output res_valid, res_data,
    input  res_ready,
    output busy,
    output res_zero, res_neg
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  res_valid, res_data,
    output res_ready,
    input  busy,
    input  res_zero, res_neg
  );
`else
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output res_valid, res_data,
    input  res_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  res_valid, res_data,
    output res_ready,
    input  busy
  );
`endif

endinterface

// File: rtl/alu_cmd_issue.sv
// Issue stage for the 4-bit combinational ALU: FIFO of {a,b,sel}, one command in flight,
// result captured one cycle after issue and offered on res_valid/res_ready.
// Ports: clk, rst_n (async, active low), bus (alu_cmd_issue_if.slave: cmd_*, alu_*, res_*, busy).
// Optional: define ALU_FLAGS_EN to add registered res_zero/res_neg alongside res_data.
module alu_cmd_issue #(
  parameter int WIDTH = 4,
  parameter int SELW  = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_cmd_issue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SELW-1:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT
  } state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_nxt;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SELW-1:0]  alu_sel;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_fire;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign push     = bus.cmd_valid && !full;
  assign res_fire = res_valid && bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Pop only from a non-empty FIFO, so a fresh command always
  // lands in storage first and issues on the following edge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (res_fire) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_EXEC;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= mem[rd_ptr].a;
      alu_b   <= mem[rd_ptr].b;
      alu_sel <= mem[rd_ptr].sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (state == S_EXEC) begin
      res_valid <= 1'b1;
      res_data  <= bus.alu_result;
    end else if (state == S_WAIT && res_fire) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  logic res_zero;
  logic res_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else if (state == S_EXEC) begin
      res_zero <= (bus.alu_result == '0);
      res_neg  <= bus.alu_result[WIDTH-1];
    end
  end

  assign bus.res_zero = res_zero;
  assign bus.res_neg  = res_neg;
`endif

  assign bus.cmd_ready = !full;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_sel   = alu_sel;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.busy      = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: ALU model on alu_*, scoreboard of expected results,
// vector table plus latency, full/stall, throughput and async-reset sequences.
module tb_alu_cmd_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issue_if #(.WIDTH(4), .SELW(3)) bus ();

  alu_cmd_issue #(.WIDTH(4), .SELW(3), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  logic [3:0] sb [$];
  logic [3:0] mon_exp;

  function automatic logic [3:0] alu_model(
    input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      default: return 4'h0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got %0h required none", bus.res_data);
      end else begin
        mon_exp = sb.pop_front();
        check("res_data", 32'(bus.res_data), 32'(mon_exp));
`ifdef ALU_FLAGS_EN
        check("res_zero", 32'(bus.res_zero), 32'(mon_exp == 4'h0));
        check("res_neg", 32'(bus.res_neg), 32'(mon_exp[3]));
`endif
      end
    end
  end

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel, input logic [3:0] exp,
                          output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    @(negedge clk);
    acc = bus.cmd_ready;
    if (acc) sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy && !bus.res_valid && sb.size() == 0) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit last;
    bit saw;
    int nacc;
    int nhs;
    int hs [8];

    tbl[0]  = '{4'h3, 4'h5, 3'b000, 4'h8};
    tbl[1]  = '{4'h2, 4'h3, 3'b001, 4'hF};
    tbl[2]  = '{4'hA, 4'h0, 3'b100, 4'h5};
    tbl[3]  = '{4'h7, 4'h7, 3'b111, 4'h0};
    tbl[4]  = '{4'hC, 4'hA, 3'b010, 4'h8};
    tbl[5]  = '{4'h5, 4'hA, 3'b011, 4'hF};
    tbl[6]  = '{4'hF, 4'h1, 3'b000, 4'h0};
    tbl[7]  = '{4'h5, 4'h5, 3'b001, 4'h0};
    tbl[8]  = '{4'h0, 4'h1, 3'b001, 4'hF};
    tbl[9]  = '{4'h9, 4'h3, 3'b101, 4'h0};
    tbl[10] = '{4'h6, 4'h2, 3'b110, 4'h0};
    tbl[11] = '{4'h4, 4'h3, 3'b100, 4'hB};

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
`ifdef ALU_FLAGS_EN
    check("rst_res_zero", 32'(bus.res_zero), 32'd0);
    check("rst_res_neg", 32'(bus.res_neg), 32'd0);
`endif
    rst_n = 1'b1;

    // Latency: push at edge k, issue at k+1, result valid after k+2.
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(4'h3, 4'h5, 3'b000, 4'h8, acc);
    check("lat_acc", 32'(acc), 32'd1);
    check("lat_alu_a_k", 32'(bus.alu_a), 32'd0);
    @(posedge clk);
    #1;
    check("lat_alu_a", 32'(bus.alu_a), 32'd3);
    check("lat_alu_b", 32'(bus.alu_b), 32'd5);
    check("lat_valid_k1", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid_k2", 32'(bus.res_valid), 32'd1);
    check("lat_data_k2", 32'(bus.res_data), 32'd8);
    drain("lat_drain");

    for (int i = 0; i < 12; i++) begin
      push_cmd(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].exp, acc);
      check("vec_acc", 32'(acc), 32'd1);
      drain("vec_drain");
    end

    // Stall: DEPTH in the FIFO plus one in flight.
    bus.res_ready = 1'b0;
    nacc = 0;
    last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(4'(i + 1), 4'h2, 3'b000, 4'(i + 3), acc);
      nacc += int'(acc);
      last = acc;
    end
    check("full_accepted", 32'(nacc), 32'd5);
    check("full_sixth_refused", 32'(last), 32'd0);
    check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("stall_valid", 32'(bus.res_valid), 32'd1);
    check("stall_data", 32'(bus.res_data), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check("stall_data_hold", 32'(bus.res_data), 32'd3);
    check("stall_valid_hold", 32'(bus.res_valid), 32'd1);

    // Release: in-order results every 2 cycles.
    bus.res_ready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.res_valid && nhs < 8) begin
        hs[nhs] = c;
        nhs++;
      end
    end
    check("thru_count", 32'(nhs), 32'd5);
    for (int i = 1; i < 5; i++) begin
      check("thru_gap", 32'(hs[i] - hs[i-1]), 32'd2);
    end
    @(posedge clk);
    #1;
    check("thru_busy", 32'(bus.busy), 32'd0);
    drain("thru_drain");

    // Async reset while waiting with two queued.
    bus.res_ready = 1'b0;
    push_cmd(4'h1, 4'h1, 3'b000, 4'h2, acc);
    push_cmd(4'h2, 4'h2, 3'b000, 4'h4, acc);
    push_cmd(4'h3, 4'h3, 3'b000, 4'h6, acc);
    check("ar_wait_valid", 32'(bus.res_valid), 32'd1);
    check("ar_busy_pre", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_res_valid", 32'(bus.res_valid), 32'd0);
    check("ar_res_data", 32'(bus.res_data), 32'd0);
    check("ar_alu_a", 32'(bus.alu_a), 32'd0);
    check("ar_alu_b", 32'(bus.alu_b), 32'd0);
    check("ar_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("ar_busy", 32'(bus.busy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw |= bus.res_valid;
    end
    check("ar_no_stale", 32'(saw), 32'd0);
    check("ar_busy_post", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
